pingpong_y_writer: RTL and testbench

PINGPONG_Y_WRITER -- requirements
Module: pingpong_y_writer

---
 rtl/pingpong_y_writer.sv | 105 ++++++++++
 tb/tb_pingpong_y_writer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_y_writer.sv
// Ping-pong y-coordinate writer.
// Accepted y samples are written into the bank the display reader is not
// using. A frame_done pulse from the reader swaps the banks and reports how
// many entries the handed-over bank holds.
module pingpong_y_writer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_y,
    output logic          in_ready,
    input  logic          frame_done,
    output logic          bank_sel,
    output logic          wr_en_a,
    output logic          wr_en_b,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          swap,
    output logic [AW:0]   frame_len,
    output logic          underrun
);

    typedef enum logic {FILL, FULL} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t      state;
    logic [AW:0] cnt;
    logic        accept;
    logic [AW:0] cnt_next;

    // in_ready is registered, so a sample is only taken when the writer
    // announced room for it in the previous cycle.
    assign accept   = in_valid & in_ready;
    // Count including a sample accepted this cycle; this is also the length
    // reported when a swap happens in the same cycle.
    assign cnt_next = cnt + {{AW{1'b0}}, accept};

    // Registered write port: strobe the bank opposite to bank_sel as seen at accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en_a <= 1'b0;
            wr_en_b <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en_a <= accept &  bank_sel;
            wr_en_b <= accept & ~bank_sel;
            if (accept) begin
                wr_addr <= cnt[AW-1:0];
                wr_data <= in_y;
            end
        end
    end

    // Fill/full control with bank swapping; frame_done overrides everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= FILL;
            cnt       <= '0;
            bank_sel  <= 1'b0;
            in_ready  <= 1'b0;
            swap      <= 1'b0;
            frame_len <= '0;
            underrun  <= 1'b0;
        end else if (frame_done) begin
            // A sample accepted now already went to the old bank, so it is
            // counted in the handed-over length and not carried forward.
            state     <= FILL;
            cnt       <= '0;
            bank_sel  <= ~bank_sel;
            in_ready  <= 1'b1;
            swap      <= 1'b1;
            frame_len <= cnt_next;
            if (cnt_next < DEPTH_C) begin
                underrun <= 1'b1;
            end
        end else begin
            swap <= 1'b0;
            cnt  <= cnt_next;
            case (state)
                FILL: begin
                    if (accept && (cnt_next == DEPTH_C)) begin
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                FULL: begin
                    // Bank full: hold off the producer until the reader swaps.
                    in_ready <= 1'b0;
                end
                default: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_y_writer.sv
// Bench for pingpong_y_writer: a behavioural bank-image model is updated on
// every driven cycle, and the RAM writes seen on the DUT ports are captured
// into two bank images for comparison.
module tb_pingpong_y_writer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_y = '0;
    logic          in_ready;
    logic          frame_done = 1'b0;
    logic          bank_sel;
    logic          wr_en_a;
    logic          wr_en_b;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap;
    logic [AW:0]   frame_len;
    logic          underrun;

    int total = 0;
    int bad   = 0;

    pingpong_y_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_y      (in_y),
        .in_ready  (in_ready),
        .frame_done(frame_done),
        .bank_sel  (bank_sel),
        .wr_en_a   (wr_en_a),
        .wr_en_b   (wr_en_b),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap      (swap),
        .frame_len (frame_len),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // Captured RAM contents and strobe counts as the DUT drives them.
    logic [DW-1:0] ram_a [DEPTH] = '{default: 8'h00};
    logic [DW-1:0] ram_b [DEPTH] = '{default: 8'h00};
    int na = 0;
    int nb = 0;
    int both = 0;

    always @(negedge clk) begin
        if (wr_en_a) begin
            ram_a[wr_addr] <= wr_data;
            na <= na + 1;
        end
        if (wr_en_b) begin
            ram_b[wr_addr] <= wr_data;
            nb <= nb + 1;
        end
        if (wr_en_a && wr_en_b) both <= both + 1;
    end

    // Reference model: what each bank should hold and what the reader sees.
    logic [DW-1:0] exp_a [DEPTH] = '{default: 8'h00};
    logic [DW-1:0] exp_b [DEPTH] = '{default: 8'h00};
    int m_wa = 0;
    int m_wb = 0;
    int m_cnt = 0;
    int m_len = 0;
    bit m_sel = 0;
    bit m_full = 0;
    bit m_under = 0;
    bit m_swap = 0;

    task automatic model_reset();
        m_cnt = 0; m_len = 0; m_sel = 0; m_full = 0; m_under = 0; m_swap = 0;
    endtask

    // Drive one clock of stimulus and advance the model; returns 1ns after the edge.
    task automatic tick(input bit v, input logic [DW-1:0] y, input bit fd);
        bit acc;
        @(negedge clk);
        in_valid = v; in_y = y; frame_done = fd;
        acc = v && !m_full;
        if (acc) begin
            if (!m_sel) begin exp_b[m_cnt] = y; m_wb++; end
            else        begin exp_a[m_cnt] = y; m_wa++; end
            m_cnt++;
        end
        if (fd) begin
            m_len = m_cnt;
            if (m_cnt < DEPTH) m_under = 1;
            m_sel = !m_sel;
            m_cnt = 0;
            m_swap = 1;
        end else begin
            m_swap = 0;
        end
        m_full = (m_cnt == DEPTH);
        @(posedge clk); #1;
        in_valid = 0; frame_done = 0;
    endtask

    task automatic test_reset();
        in_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL reset_bank_sel got=%b want=0", bank_sel); end
        total++; if ({wr_en_a, wr_en_b} !== 2'b00) begin bad++; $display("FAIL reset_wr_en got=%b want=00", {wr_en_a, wr_en_b}); end
        total++; if ({wr_addr, wr_data} !== '0) begin bad++; $display("FAIL reset_addr_data got=%h/%h want=0/0", wr_addr, wr_data); end
        total++; if ({swap, frame_len, underrun} !== '0) begin bad++; $display("FAIL reset_status got=%b/%0d/%b want=0/0/0", swap, frame_len, underrun); end
        in_valid = 0;
        @(negedge clk); resetn = 1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_fill();
        int b0;
        int a0;
        b0 = nb; a0 = na;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b want=1", i, in_ready); end
            tick(1, DW'(i), 0);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b want=0", in_ready); end
        tick(0, 0, 0);
        total++; if (nb - b0 !== DEPTH) begin bad++; $display("FAIL fill_b_strobes got=%0d want=%0d", nb - b0, DEPTH); end
        total++; if (na - a0 !== 0) begin bad++; $display("FAIL fill_a_strobes got=%0d want=0", na - a0); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (ram_b[i] !== DW'(i)) begin bad++; $display("FAIL fill_ram_b[%0d] got=%h want=%h", i, ram_b[i], DW'(i)); end
        end
    endtask

    task automatic test_swap_full();
        int a0;
        int b0;
        tick(0, 0, 1);
        total++; if (bank_sel !== 1'b1) begin bad++; $display("FAIL swap_bank_sel got=%b want=1", bank_sel); end
        total++; if (swap !== 1'b1) begin bad++; $display("FAIL swap_pulse got=%b want=1", swap); end
        total++; if (frame_len !== 5'(DEPTH)) begin bad++; $display("FAIL swap_frame_len got=%0d want=%0d", frame_len, DEPTH); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL swap_underrun got=%b want=0", underrun); end
        a0 = na; b0 = nb;
        tick(0, 0, 0);
        total++; if (swap !== 1'b0) begin bad++; $display("FAIL swap_pulse_end got=%b want=0", swap); end
        for (int i = 0; i < DEPTH; i++) tick(1, DW'($urandom_range(0, 255)), 0);
        tick(0, 0, 0);
        total++; if (na - a0 !== DEPTH || nb - b0 !== 0) begin bad++; $display("FAIL swap_refill_strobes got=a%0d/b%0d want=a%0d/b0", na - a0, nb - b0, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (ram_a[i] !== exp_a[i]) begin bad++; $display("FAIL swap_ram_a[%0d] got=%h want=%h", i, ram_a[i], exp_a[i]); end
        end
    endtask

    task automatic test_hold_full();
        int a0;
        int b0;
        a0 = na; b0 = nb;
        for (int i = 0; i < 10; i++) begin
            tick(1, DW'($urandom_range(0, 255)), 0);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%b want=0", i, in_ready); end
        end
        tick(0, 0, 0);
        total++; if (na - a0 !== 0 || nb - b0 !== 0) begin bad++; $display("FAIL hold_strobes got=a%0d/b%0d want=0/0", na - a0, nb - b0); end
        tick(0, 0, 1);
        total++; if (bank_sel !== 1'b0 || frame_len !== 5'(DEPTH)) begin bad++; $display("FAIL hold_swap got=%b/%0d want=0/%0d", bank_sel, frame_len, DEPTH); end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 5; i++) tick(1, DW'($urandom_range(0, 255)), 0);
        tick(0, 0, 1);
        total++; if (frame_len !== 5'd5) begin bad++; $display("FAIL under_frame_len got=%0d want=5", frame_len); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL under_flag got=%b want=1", underrun); end
        for (int i = 0; i < DEPTH; i++) tick(1, DW'($urandom_range(0, 255)), 0);
        tick(0, 0, 1);
        total++; if (frame_len !== 5'(DEPTH)) begin bad++; $display("FAIL under_full_len got=%0d want=%0d", frame_len, DEPTH); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL under_sticky got=%b want=1", underrun); end
    endtask

    task automatic test_same_cycle();
        bit old_sel;
        logic [DW-1:0] y;
        logic [DW-1:0] got;
        for (int i = 0; i < 3; i++) tick(1, DW'($urandom_range(0, 255)), 0);
        old_sel = m_sel;
        tick(1, 8'h7F, 1);
        total++; if (frame_len !== 5'd4) begin bad++; $display("FAIL same_frame_len got=%0d want=4", frame_len); end
        y = DW'($urandom_range(0, 255));
        tick(1, y, 0);
        tick(0, 0, 0);
        got = old_sel ? ram_a[3] : ram_b[3];
        total++; if (got !== 8'h7F) begin bad++; $display("FAIL same_old_bank_addr3 got=%h want=7f", got); end
        got = old_sel ? ram_b[0] : ram_a[0];
        total++; if (got !== y) begin bad++; $display("FAIL same_new_bank_addr0 got=%h want=%h", got, y); end
    endtask

    task automatic test_fd_held();
        bit s0;
        s0 = m_sel;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1);
            total++; if (swap !== 1'b1 || bank_sel !== m_sel) begin bad++; $display("FAIL held_fd[%0d] got=%b/%b want=1/%b", i, swap, bank_sel, m_sel); end
        end
        total++; if (bank_sel !== !s0) begin bad++; $display("FAIL held_fd_parity got=%b want=%b", bank_sel, !s0); end
        total++; if (frame_len !== 5'd0) begin bad++; $display("FAIL held_fd_len got=%0d want=0", frame_len); end
    endtask

    task automatic test_random();
        bit v;
        bit fd;
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            fd = ($urandom_range(0, 24) == 0);
            tick(v, DW'($urandom_range(0, 255)), fd);
            total++;
            if (in_ready !== !m_full || bank_sel !== m_sel || swap !== m_swap ||
                frame_len !== 5'(m_len) || underrun !== m_under) begin
                bad++;
                $display("FAIL rand[%0d] got=rdy%b sel%b sw%b len%0d ur%b want=rdy%b sel%b sw%b len%0d ur%b",
                         i, in_ready, bank_sel, swap, frame_len, underrun, !m_full, m_sel, m_swap, m_len, m_under);
            end
        end
        tick(0, 0, 0);
        total++; if (na !== m_wa || nb !== m_wb) begin bad++; $display("FAIL rand_strobes got=a%0d/b%0d want=a%0d/b%0d", na, nb, m_wa, m_wb); end
        total++; if (both !== 0) begin bad++; $display("FAIL rand_both_strobes got=%0d want=0", both); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (ram_a[i] !== exp_a[i] || ram_b[i] !== exp_b[i]) begin
                bad++; $display("FAIL rand_ram[%0d] got=%h/%h want=%h/%h", i, ram_a[i], ram_b[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        int b0;
        logic [DW-1:0] saved;
        logic [DW-1:0] ys [3];
        @(negedge clk); resetn = 0; model_reset();
        @(negedge clk); resetn = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) tick(1, DW'($urandom_range(0, 255)), 0);
        saved = exp_b[6];
        tick(1, 8'hA5, 0);
        a0 = na; b0 = nb;
        resetn = 0;
        #1;
        exp_b[6] = saved; m_wb--; model_reset();
        total++; if ({wr_en_a, wr_en_b} !== 2'b00) begin bad++; $display("FAIL mid_reset_wr_en got=%b want=00", {wr_en_a, wr_en_b}); end
        total++; if ({wr_addr, wr_data} !== '0) begin bad++; $display("FAIL mid_reset_addr_data got=%h/%h want=0/0", wr_addr, wr_data); end
        total++; if ({in_ready, bank_sel, swap, frame_len, underrun} !== '0) begin bad++; $display("FAIL mid_reset_status got=%b%b%b/%0d/%b want=0", in_ready, bank_sel, swap, frame_len, underrun); end
        @(negedge clk); resetn = 1;
        @(posedge clk); #1;
        total++; if (na !== a0 || nb !== b0) begin bad++; $display("FAIL mid_reset_cancel got=a%0d/b%0d want=a%0d/b%0d", na, nb, a0, b0); end
        for (int i = 0; i < 3; i++) begin
            ys[i] = DW'($urandom_range(0, 255));
            tick(1, ys[i], 0);
        end
        tick(0, 0, 0);
        total++; if (nb - b0 !== 3 || na !== a0) begin bad++; $display("FAIL mid_restart_strobes got=a%0d/b%0d want=a0/b3", na - a0, nb - b0); end
        for (int i = 0; i < 3; i++) begin
            total++; if (ram_b[i] !== ys[i]) begin bad++; $display("FAIL mid_restart_ram_b[%0d] got=%h want=%h", i, ram_b[i], ys[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_swap_full();
        test_hold_full();
        test_underrun();
        test_same_cycle();
        test_fd_held();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
